// File: rtl/traffic_light_controller.sv
// Three-aspect traffic-light sequencer: RED -> GREEN -> YELLOW -> RED, each phase DUR enabled cycles.
// Latency: lamp outputs are a registered-state decode and change right after the terminal enabled edge.
// Backpressure: enable = 0 freezes state and phase counter; no combinational path from enable to lamps.
module traffic_light_controller #(
  parameter int unsigned RED_CYCLES    = 32,
  parameter int unsigned GREEN_CYCLES  = 20,
  parameter int unsigned YELLOW_CYCLES = 7,
  parameter int unsigned CNT_W         = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic red,
  output logic yellow,
  output logic green
);

  // Binary state encoding; 2'b11 is unused and recovers to RED.
  localparam logic [1:0] S_RED    = 2'b00;
  localparam logic [1:0] S_GREEN  = 2'b01;
  localparam logic [1:0] S_YELLOW = 2'b10;

  // Terminal counts for each phase (counter runs 0 .. DUR-1).
  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_state_adv;
  logic             w_last;
  logic             w_illegal;

  // State and phase counter registers; reset forces RED with a fresh count immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RED;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and next-count: advance on terminal count, otherwise count up; hold when disabled.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_state_adv = S_RED;
    w_last      = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      S_RED: begin
        w_last      = (r_cnt == RED_LAST);
        w_state_adv = S_GREEN;
      end
      S_GREEN: begin
        w_last      = (r_cnt == GREEN_LAST);
        w_state_adv = S_YELLOW;
      end
      S_YELLOW: begin
        w_last      = (r_cnt == YELLOW_LAST);
        w_state_adv = S_RED;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase

    if (w_illegal) begin
      // Unused encoding recovers on the very next edge, even while frozen.
      w_state_nxt = S_RED;
      w_cnt_nxt   = '0;
    end else if (enable) begin
      if (w_last) begin
        w_state_nxt = w_state_adv;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  // One-hot lamp decode of the state register; unused encoding shows RED.
  always_comb begin
    red    = (r_state == S_RED) || (r_state == 2'b11);
    green  = (r_state == S_GREEN);
    yellow = (r_state == S_YELLOW);
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller: default-parameter DUT plus a 2/1/1 override DUT.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
// Expected lamp patterns are hand-computed from phase lengths.
module tb_traffic_light_controller;

  logic clk;
  logic reset;
  logic enable;
  logic red, yellow, green;
  logic s_red, s_yellow, s_green;

  int n_total;
  int n_bad;

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;

  traffic_light_controller u_dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .red    (red),
    .yellow (yellow),
    .green  (green)
  );

  traffic_light_controller #(
    .RED_CYCLES    (2),
    .GREEN_CYCLES  (1),
    .YELLOW_CYCLES (1),
    .CNT_W         (6)
  ) u_small (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .red    (s_red),
    .yellow (s_yellow),
    .green  (s_green)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle to the sampling point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] lamps_main();
    return {red, yellow, green};
  endfunction

  function automatic logic [2:0] lamps_small();
    return {s_red, s_yellow, s_green};
  endfunction

  initial begin
    logic [2:0] exp_main;
    logic [2:0] exp_small;
    n_total = 0;
    n_bad   = 0;

    // Reset asserted before any clock edge: lamps must be RED at once.
    reset  = 1'b1;
    enable = 1'b1;
    #1;
    chk("reset_async_main", 32'(lamps_main()), 32'(L_R));
    chk("reset_async_small", 32'(lamps_small()), 32'(L_R));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold", 32'(lamps_main()), 32'(L_R));
    end
    reset = 1'b0;

    // Full sequence with enable held: 32 red, 20 green, 7 yellow, red again at edge 59.
    for (int e = 1; e <= 59; e++) begin
      step();
      if (e < 32)      exp_main = L_R;
      else if (e < 52) exp_main = L_G;
      else if (e < 59) exp_main = L_Y;
      else             exp_main = L_R;
      chk($sformatf("seq_e%0d", e), 32'(lamps_main()), 32'(exp_main));
      chk("onehot", 32'($countones(lamps_main())), 32'd1);
      if (e <= 12) begin
        case (e % 4)
          0, 1:    exp_small = L_R;
          2:       exp_small = L_G;
          default: exp_small = L_Y;
        endcase
        chk($sformatf("small_e%0d", e), 32'(lamps_small()), 32'(exp_small));
      end
    end

    // Second lap: red for 31 more edges, green on the 32nd.
    for (int e = 1; e <= 32; e++) begin
      step();
      chk("lap2_red_to_green", 32'(lamps_main()), 32'(e < 32 ? L_R : L_G));
    end

    // Ten green cycles, then a 5-edge pause, then 10 more enabled green edges.
    for (int e = 1; e <= 10; e++) begin
      step();
      chk("green_pre_pause", 32'(lamps_main()), 32'(L_G));
    end
    enable = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("green_paused", 32'(lamps_main()), 32'(L_G));
    end
    enable = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      chk("green_post_pause", 32'(lamps_main()), 32'(e < 10 ? L_G : L_Y));
    end

    // Two enabled yellow edges, then reset mid-cycle during the third yellow cycle.
    for (int e = 1; e <= 2; e++) begin
      step();
      chk("yellow_pre_reset", 32'(lamps_main()), 32'(L_Y));
    end
    #2;
    reset = 1'b1;
    #1;
    chk("mid_yellow_reset_async", 32'(lamps_main()), 32'(L_R));
    step();
    chk("mid_yellow_reset_hold", 32'(lamps_main()), 32'(L_R));
    reset = 1'b0;

    // Full red phase restarts: 31 edges reach the terminal count, still red.
    for (int e = 1; e <= 31; e++) begin
      step();
      chk("red_restart", 32'(lamps_main()), 32'(L_R));
    end
    // Pause exactly at the terminal count: no transition while frozen.
    enable = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      step();
      chk("red_terminal_paused", 32'(lamps_main()), 32'(L_R));
    end
    enable = 1'b1;
    step();
    chk("red_terminal_release", 32'(lamps_main()), 32'(L_G));
    chk("onehot_final", 32'($countones(lamps_main())), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_light_controller.md
# traffic_light_controller

Cyclic three-aspect traffic-light sequencer driving one red/yellow/green lamp group. It runs a fixed RED → GREEN → YELLOW → RED sequence. Each phase lasts a parameterised number of enabled clock cycles, and a global enable lets the surrounding control logic freeze the sequence. It sits at the leaf of the intersection controller and drives the lamp drivers directly.

## Interface
Parameters:
- RED_CYCLES, default 32, number of enabled cycles spent in RED (≥ 1)
- GREEN_CYCLES, default 20, number of enabled cycles spent in GREEN (≥ 1)
- YELLOW_CYCLES, default 7, number of enabled cycles spent in YELLOW (≥ 1)
- CNT_W, default 6, phase counter width; must hold max(*_CYCLES) − 1

Ports:
- clk  input  1  single system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- enable  input  1  1 = sequence advances this cycle; 0 = freeze state and counter
- red  output  1  red lamp on
- yellow  output  1  yellow lamp on
- green  output  1  green lamp on

One clock; reset is asynchronous and active-high.

## Operation
- State machine, three states with binary encoding: RED, GREEN, YELLOW.
- A phase counter `cnt` (CNT_W bits) counts enabled cycles within the current state.
- The rising edge with enable = 1 behaves as follows:
  - if cnt == DUR(state) − 1: go to the next state and set cnt = 0
  - otherwise: cnt = cnt + 1, state unchanged
- Next state order: RED → GREEN, GREEN → YELLOW, YELLOW → RED.
- Rising edge with enable = 0: state and cnt hold. Pauses of any length do not lose or add counts.
- Outputs are a one-hot decode of the state register:
  - red = (state == RED)
  - green = (state == GREEN)
  - yellow = (state == YELLOW)
- Exactly one lamp is high at all times, including during reset. No all-off or multi-on state exists.
- Unused state encoding (binary 11) decodes as RED on the outputs. It goes to RED with cnt = 0 on the next edge, regardless of enable.
- Counter arithmetic is unsigned. The cnt never exceeds DUR − 1, so no wrap-around occurs.

## Timing
- Reset asserted (asynchronous): state = RED and cnt = 0 immediately, without waiting for a clock edge.
  - Outputs during reset: red = 1, yellow = 0, green = 0.
- Reset deassertion: the first edge that can advance the sequence is the first rising edge with reset low and enable = 1.
- Reset asserted mid-phase (any state, any cnt): the block returns to RED with cnt = 0 at once. The RED phase then restarts at its full length.
- Phase length: a state persists for exactly DUR enabled rising edges. The output change is visible right after the DUR-th enabled edge, so latency is 0 cycles from the edge to the outputs.
- With enable held high and default parameters, one full cycle is 59 clocks: 32 red, 20 green, 7 yellow.
- Enable changing together with a terminal count: the value sampled at that edge decides. With enable = 0 at cnt == DUR − 1 there is no transition; the transition happens on the next edge that has enable = 1.
- There is no combinational path from enable to the outputs.

## Test plan
- Reset check: assert reset with enable = 1, clock running, from any state. Required: red = 1, yellow = 0, green = 0 before the next clock edge; the outputs hold while reset stays high.
- Full sequence: release reset, then hold enable = 1.
  - Red stays high for exactly 32 edges.
  - Green then stays high for exactly 20 edges.
  - Yellow then stays high for exactly 7 edges.
  - Red returns at edge 59.
  - The one-hot property holds at every cycle.
- Pause in mid-GREEN: after 10 green cycles, drop enable for 5 edges. Required: green holds throughout the pause, and green lasts 10 more enabled edges after enable returns.
- Pause at a terminal count: enable = 0 on the edge where cnt == RED_CYCLES − 1. Required: red stays. Green appears on the first edge after enable returns to 1.
- Mid-YELLOW reset: assert reset on the 3rd yellow cycle, release it, then hold enable = 1. Required: red immediately, then a full 32-cycle red phase before green.
- Parameter override: RED_CYCLES = 2, GREEN_CYCLES = 1, YELLOW_CYCLES = 1, enable high. Required: a 4-cycle period with pattern R,R,G,Y repeating.
